// File: rtl/vga_timing_pkg.sv
// Shared mode presets and axis timing bundle for the raster generator.
// Optional frame counter lives in vga_timing_gen (VGA_TIMING_FRAME_CNT_EN).
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] syn;
    logic [15:0] bkporch;
    logic [15:0] data;
    logic [15:0] ftporch;
  } axis_cfg_t;

  localparam axis_cfg_t H_640X480 =
    '{16'd96, 16'd48, 16'd640, 16'd16};
  localparam axis_cfg_t V_640X480 =
    '{16'd2, 16'd33, 16'd480, 16'd10};

  localparam axis_cfg_t H_800X600 =
    '{16'd128, 16'd88, 16'd800, 16'd40};
  localparam axis_cfg_t V_800X600 =
    '{16'd4, 16'd23, 16'd600, 16'd1};

  // reduced-blanking 1440x900@60
  localparam axis_cfg_t H_1440X900 =
    '{16'd32, 16'd80, 16'd1440, 16'd48};
  localparam axis_cfg_t V_1440X900 =
    '{16'd6, 16'd17, 16'd900, 16'd3};

  function automatic int unsigned axis_total(
    input axis_cfg_t c
  );
    return 32'(c.syn) + 32'(c.bkporch) +
           32'(c.data) + 32'(c.ftporch);
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One raster axis: wrapping position counter plus
// sync / active / lead-shifted active decode.
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter axis_cfg_t CFG   = H_1440X900,
  parameter int        LEAD  = 0,
  parameter int        CNT_W = 12
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Clr,
  input  logic             Adv,
  output logic [CNT_W-1:0] Cnt,
  output logic             Sync,
  output logic             Act,
  output logic             Lead_Act,
  output logic [CNT_W-1:0] Lead_Pos
);

  localparam int TOTAL = int'(axis_total(CFG));
  localparam int START = int'(CFG.syn) + int'(CFG.bkporch);
  localparam int STOP  = START + int'(CFG.data);

  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYN_C   = CNT_W'(CFG.syn);
  localparam logic [CNT_W-1:0] START_C = CNT_W'(START);
  localparam logic [CNT_W-1:0] STOP_C  = CNT_W'(STOP);
  localparam logic [CNT_W-1:0] LEAD_C  = CNT_W'(LEAD);

  logic [CNT_W-1:0] lead_cnt;

  always_ff @(posedge CLK) begin
    if (!RSTn || Clr) begin
      Cnt <= '0;
    end else if (Adv) begin
      Cnt <= (Cnt == LAST_C) ? '0 : Cnt + CNT_W'(1);
    end
  end

  assign lead_cnt = Cnt + LEAD_C;
  assign Sync     = Cnt < SYN_C;
  assign Act      = (Cnt >= START_C) && (Cnt < STOP_C);
  assign Lead_Act = (lead_cnt >= START_C) &&
                    (lead_cnt < STOP_C);
  assign Lead_Pos = lead_cnt - START_C;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with registered outputs.
// VGA_TIMING_FRAME_CNT_EN adds a wrapping frame counter output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYN      = 32,
  parameter int H_BKPORCH  = 80,
  parameter int H_DATA     = 1440,
  parameter int H_FTPORCH  = 48,
  parameter int V_SYN      = 6,
  parameter int V_BKPORCH  = 17,
  parameter int V_DATA     = 900,
  parameter int V_FTPORCH  = 3,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int FETCH_LEAD = 1,
  parameter int CNT_W      = 12,
  parameter int ADDR_W     = 11
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  parameter int FRAME_CNT_W = 8
`endif
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              En,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig,
  output logic              DE_Sig,
  output logic              Fetch_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig,
  output logic              Line_Start_Sig,
  output logic              Frame_Start_Sig
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] Frame_Cnt_Sig
`endif
);

  localparam axis_cfg_t H_CFG = '{
    16'(H_SYN), 16'(H_BKPORCH), 16'(H_DATA), 16'(H_FTPORCH)
  };
  localparam axis_cfg_t V_CFG = '{
    16'(V_SYN), 16'(V_BKPORCH), 16'(V_DATA), 16'(V_FTPORCH)
  };

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(axis_total(H_CFG) - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(axis_total(V_CFG) - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_pos, v_pos;
  logic             h_sync, v_sync;
  logic             h_act, v_act;
  logic             h_lead, v_lead;
  logic             h_wrap, fetch;

  assign h_wrap = En && (h_cnt == H_LAST);

  vga_timing_axis #(
    .CFG   (H_CFG),
    .LEAD  (FETCH_LEAD),
    .CNT_W (CNT_W)
  ) u_h (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Clr      (!En),
    .Adv      (En),
    .Cnt      (h_cnt),
    .Sync     (h_sync),
    .Act      (h_act),
    .Lead_Act (h_lead),
    .Lead_Pos (h_pos)
  );

  vga_timing_axis #(
    .CFG   (V_CFG),
    .LEAD  (0),
    .CNT_W (CNT_W)
  ) u_v (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Clr      (!En),
    .Adv      (h_wrap),
    .Cnt      (v_cnt),
    .Sync     (v_sync),
    .Act      (v_act),
    .Lead_Act (v_lead),
    .Lead_Pos (v_pos)
  );

  assign fetch = h_lead && v_lead;

  always_ff @(posedge CLK) begin
    if (!RSTn || !En) begin
      HSYNC_Sig       <= ~H_POL;
      VSYNC_Sig       <= ~V_POL;
      DE_Sig          <= 1'b0;
      Fetch_Sig       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Line_Start_Sig  <= 1'b0;
      Frame_Start_Sig <= 1'b0;
    end else begin
      HSYNC_Sig       <= h_sync ? H_POL : ~H_POL;
      VSYNC_Sig       <= v_sync ? V_POL : ~V_POL;
      DE_Sig          <= h_act && v_act;
      Fetch_Sig       <= fetch;
      Column_Addr_Sig <= fetch ? ADDR_W'(h_pos) : '0;
      Row_Addr_Sig    <= fetch ? ADDR_W'(v_pos) : '0;
      Line_Start_Sig  <= h_cnt == '0;
      Frame_Start_Sig <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;

  // delayed one clock to line up with Frame_Start_Sig
  always_ff @(posedge CLK) begin
    if (!RSTn || !En) begin
      frame_cnt     <= '0;
      Frame_Cnt_Sig <= '0;
    end else begin
      if (h_wrap && (v_cnt == V_LAST)) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
      Frame_Cnt_Sig <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: directed steps plus random En/reset
// against a frame-position arithmetic model.
module tb_vga_timing_gen;

  localparam int HSY = 2, HBP = 3, HDA = 8, HFP = 2;
  localparam int VSY = 1, VBP = 1, VDA = 4, VFP = 1;
  localparam int HT  = HSY + HBP + HDA + HFP;
  localparam int VT  = VSY + VBP + VDA + VFP;
  localparam int HST = HSY + HBP;
  localparam int VST = VSY + VBP;
  localparam int LD  = 2;
  localparam int AW  = 11;
  localparam int FCW = 2;

  typedef struct {
    logic          hs, vs, de, fe, ls, fs;
    logic [AW-1:0] col, row;
  } exp_t;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic En = 1'b0;

  logic [1:0]    hs, vs, de, fe, ls, fs;
  logic [AW-1:0] col [2];
  logic [AW-1:0] row [2];
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCW-1:0] fc [2];
`endif

  int checks = 0;
  int failures = 0;
  int n = 0;

  always #5 CLK = ~CLK;

  vga_timing_gen #(
    .H_SYN(HSY), .H_BKPORCH(HBP), .H_DATA(HDA), .H_FTPORCH(HFP),
    .V_SYN(VSY), .V_BKPORCH(VBP), .V_DATA(VDA), .V_FTPORCH(VFP),
    .H_POL(1'b0), .V_POL(1'b0), .FETCH_LEAD(LD),
    .CNT_W(12), .ADDR_W(AW)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .FRAME_CNT_W(FCW)
`endif
  ) u0 (
    .CLK(CLK), .RSTn(RSTn), .En(En),
    .HSYNC_Sig(hs[0]), .VSYNC_Sig(vs[0]),
    .DE_Sig(de[0]), .Fetch_Sig(fe[0]),
    .Column_Addr_Sig(col[0]), .Row_Addr_Sig(row[0]),
    .Line_Start_Sig(ls[0]), .Frame_Start_Sig(fs[0])
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .Frame_Cnt_Sig(fc[0])
`endif
  );

  vga_timing_gen #(
    .H_SYN(HSY), .H_BKPORCH(HBP), .H_DATA(HDA), .H_FTPORCH(HFP),
    .V_SYN(VSY), .V_BKPORCH(VBP), .V_DATA(VDA), .V_FTPORCH(VFP),
    .H_POL(1'b1), .V_POL(1'b1), .FETCH_LEAD(LD),
    .CNT_W(12), .ADDR_W(AW)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .FRAME_CNT_W(FCW)
`endif
  ) u1 (
    .CLK(CLK), .RSTn(RSTn), .En(En),
    .HSYNC_Sig(hs[1]), .VSYNC_Sig(vs[1]),
    .DE_Sig(de[1]), .Fetch_Sig(fe[1]),
    .Column_Addr_Sig(col[1]), .Row_Addr_Sig(row[1]),
    .Line_Start_Sig(ls[1]), .Frame_Start_Sig(fs[1])
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .Frame_Cnt_Sig(fc[1])
`endif
  );

  // expected outputs for the frame position reached after
  // p counted clocks (outputs lag the counters by one clock)
  function automatic exp_t model(
    input int p, input bit hp, input bit vp, input bit run
  );
    exp_t e;
    int h, v;
    bit vrow;
    e.hs = ~hp; e.vs = ~vp; e.de = 0; e.fe = 0;
    e.ls = 0; e.fs = 0; e.col = '0; e.row = '0;
    if (run) begin
      h = (p % (HT * VT)) % HT;
      v = (p % (HT * VT)) / HT;
      vrow = (v >= VST) && (v < VST + VDA);
      e.hs = (h < HSY) ? hp : ~hp;
      e.vs = (v < VSY) ? vp : ~vp;
      e.de = (h >= HST) && (h < HST + HDA) && vrow;
      e.fe = (h + LD >= HST) && (h + LD < HST + HDA) && vrow;
      e.col = e.fe ? AW'(h + LD - HST) : '0;
      e.row = e.fe ? AW'(v - VST) : '0;
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic chk(
    input string tag, input int obs, input int exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic step(input bit rst_n, input bit en);
    exp_t e0, e1;
    bit run;
    int p;
    RSTn = rst_n;
    En = en;
    @(posedge CLK);
    #1;
    run = rst_n && en;
    p = n;
    e0 = model(p, 1'b0, 1'b0, run);
    e1 = model(p, 1'b1, 1'b1, run);
    n = run ? n + 1 : 0;
    chk("hsync", int'(hs[0]), int'(e0.hs));
    chk("vsync", int'(vs[0]), int'(e0.vs));
    chk("de", int'(de[0]), int'(e0.de));
    chk("fetch", int'(fe[0]), int'(e0.fe));
    chk("col", int'(col[0]), int'(e0.col));
    chk("row", int'(row[0]), int'(e0.row));
    chk("line_start", int'(ls[0]), int'(e0.ls));
    chk("frame_start", int'(fs[0]), int'(e0.fs));
    chk("hsync_pol1", int'(hs[1]), int'(e1.hs));
    chk("vsync_pol1", int'(vs[1]), int'(e1.vs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_cnt", int'(fc[0]),
        run ? (p / (HT * VT)) % (1 << FCW) : 0);
`endif
  endtask

  initial begin
    step(0, 1);
    chk("rst_hsync", int'(hs[0]), 1);
    chk("rst_hsync_pol1", int'(hs[1]), 0);
    step(0, 1);

    // full frame plus a little after reset release
    for (int i = 0; i < 110; i++) begin
      step(1, 1);
      if (n == 1) chk("fs_first", int'(fs[0]), 1);
      if (n == 1) chk("hs_clk1", int'(hs[0]), 0);
      if (n == 2) chk("hs_clk2", int'(hs[0]), 0);
      if (n == 3) chk("hs_clk3", int'(hs[0]), 1);
      if (n == 16) chk("ls_line1", int'(ls[0]), 1);
      if (n == 16) chk("fs_line1", int'(fs[0]), 0);
      if (n == 15) chk("vs_clk15", int'(vs[0]), 0);
      if (n == 16) chk("vs_clk16", int'(vs[0]), 1);
      if (n == 34) chk("fetch_rise", int'(fe[0]), 1);
      if (n == 34) chk("col_first", int'(col[0]), 0);
      if (n == 35) chk("de_before", int'(de[0]), 0);
      if (n == 36) chk("de_rise", int'(de[0]), 1);
      if (n == 41) chk("col_last", int'(col[0]), HDA - 1);
      if (n == 42) chk("fetch_fall", int'(fe[0]), 0);
      if (n == 43) chk("de_last", int'(de[0]), 1);
      if (n == 44) chk("de_fall", int'(de[0]), 0);
      if (n == 79) chk("row_last", int'(row[0]), VDA - 1);
      if (n == 94) chk("v6_fetch", int'(fe[0]), 0);
      if (n == 106) chk("fs_frame2", int'(fs[0]), 1);
      if (n == 106) chk("ls_frame2", int'(ls[0]), 1);
    end

    // drop En at h=7 v=3 of a fresh frame
    step(1, 0);
    for (int i = 0; i < 52; i++) step(1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      chk("en0_hsync", int'(hs[0]), 1);
      chk("en0_fetch", int'(fe[0]), 0);
    end
    step(1, 1);
    chk("reen_fs", int'(fs[0]), 1);

    // mid-frame reset with active-high syncs
    for (int i = 0; i < 19; i++) step(1, 1);
    step(0, 1);
    chk("rst_mid_hs_pol1", int'(hs[1]), 0);
    chk("rst_mid_vs_pol1", int'(vs[1]), 0);

    // five whole frames (frame counter wrap when enabled)
    for (int i = 0; i < 5 * HT * VT + 2; i++) step(1, 1);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 59) != 0, $urandom_range(0, 24) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
